// File: rtl/uart_status_tx.sv
// uart_status_tx: on a report request, snapshots the command-FSM state and
// relay level and sends an ASCII status frame ("S", state digit, relay digit,
// LF) on an 8N1 UART line.
// Optional build macro STATUS_CRLF_EN: adds a CR before the LF (5-byte frame).
module uart_status_tx #(
  parameter int CLK_HZ       = 12000000,
  parameter int BAUD         = 9600,
  parameter int CLKS_PER_BIT = CLK_HZ / BAUD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       report,
  input  logic [1:0] state_in,
  input  logic       relay_in,
  output logic       tx,
  output logic       busy,
  output logic       done
);

`ifdef STATUS_CRLF_EN
  localparam int NBYTES = 5;
`else
  localparam int NBYTES = 4;
`endif

  localparam int              TMR_W     = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       BYTE_LAST = 3'(NBYTES - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state;
  logic [TMR_W-1:0] tmr;
  logic [2:0]       bit_idx;
  logic [2:0]       byte_idx;
  logic             pending;
  logic [7:0]       shreg;
  logic [1:0]       snap_state;
  logic             snap_relay;

  // Byte idx of the status frame, built from the snapshotted control state.
  function automatic logic [7:0] frame_byte(input logic [2:0] idx,
                                            input logic [1:0] st,
                                            input logic       rl);
    logic [7:0] b;
    case (idx)
      3'd0:    b = 8'h53;
      3'd1:    b = 8'h30 + {6'd0, st};
      3'd2:    b = 8'h30 + {7'd0, rl};
`ifdef STATUS_CRLF_EN
      3'd3:    b = 8'h0D;
`endif
      default: b = 8'h0A;
    endcase
    return b;
  endfunction

  // Message sequencer and 8N1 serialiser; tx, busy and done are registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      pending  <= 1'b0;
      tmr      <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
    end else begin
      done <= 1'b0;
      // Any report outside IDLE (including the final stop-bit cycle) queues one frame.
      if (report && state != IDLE) pending <= 1'b1;
      case (state)
        IDLE: begin
          if (report || pending) begin
            state      <= START;
            tx         <= 1'b0;
            busy       <= 1'b1;
            pending    <= 1'b0;
            tmr        <= '0;
            bit_idx    <= '0;
            byte_idx   <= '0;
            snap_state <= state_in;
            snap_relay <= relay_in;
            shreg      <= frame_byte(3'd0, state_in, relay_in);
          end
        end
        START: begin
          if (tmr == TMR_LAST) begin
            tmr     <= '0;
            state   <= DATA;
            bit_idx <= '0;
            tx      <= shreg[0];
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        DATA: begin
          if (tmr == TMR_LAST) begin
            tmr <= '0;
            if (bit_idx == 3'd7) begin
              state   <= STOP;
              bit_idx <= '0;
              tx      <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              shreg   <= shreg >> 1;
              tx      <= shreg[1];
            end
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        STOP: begin
          if (tmr == TMR_LAST) begin
            tmr <= '0;
            if (byte_idx == BYTE_LAST) begin
              state    <= IDLE;
              busy     <= 1'b0;
              done     <= 1'b1;
              byte_idx <= '0;
            end else begin
              state    <= START;
              tx       <= 1'b0;
              byte_idx <= byte_idx + 1'b1;
              shreg    <= frame_byte(byte_idx + 3'd1, snap_state, snap_relay);
            end
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_status_tx.sv
// Testbench for uart_status_tx: directed scenarios plus randomized traffic,
// checked cycle by cycle against a frame-level reference model.
module tb_uart_status_tx;

  localparam int CPB = 16;
`ifdef STATUS_CRLF_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif
  localparam int FRAME = NB * 10 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       report = 1'b0;
  logic [1:0] state_in = 2'd0;
  logic       relay_in = 1'b0;
  logic       tx, busy, done;

  int n_tests = 0;
  int n_fail  = 0;

  uart_status_tx #(.CLK_HZ(16), .BAUD(1)) dut (
    .clk(clk), .rst(rst), .report(report), .state_in(state_in),
    .relay_in(relay_in), .tx(tx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a frame is a list of bytes; tx at elapsed cycle e is
  // bit (e / CPB) of the 10-bits-per-byte line sequence.
  bit         m_valid = 0;
  bit         m_active = 0;
  bit         m_pend = 0;
  int         m_e = 0;
  logic [7:0] m_bytes[NB];
  logic       exp_tx = 1'b1, exp_busy = 1'b0, exp_done = 1'b0;
  int         m_done_cnt = 0, obs_done_cnt = 0;

  function automatic logic line_bit(input int e);
    int b, pos, k;
    b   = e / CPB;
    k   = b / 10;
    pos = b % 10;
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return m_bytes[k][pos-1];
  endfunction

  always @(posedge clk) begin
    exp_done = 1'b0;
    if (rst) begin
      m_valid  = 1;
      m_active = 0;
      m_pend   = 0;
    end else if (m_active) begin
      if (report) m_pend = 1;
      m_e++;
      if (m_e == FRAME) begin
        m_active = 0;
        exp_done = 1'b1;
        m_done_cnt++;
      end
    end else if (report || m_pend) begin
      m_active   = 1;
      m_pend     = 0;
      m_e        = 0;
      m_bytes[0] = "S";
      m_bytes[1] = 8'h30 + 8'(state_in);
      m_bytes[2] = 8'h30 + 8'(relay_in);
      if (NB == 5) begin
        m_bytes[3] = 8'h0D;
        m_bytes[4] = 8'h0A;
      end else begin
        m_bytes[3] = 8'h0A;
      end
    end
    exp_busy = m_active;
    exp_tx   = m_active ? line_bit(m_e) : 1'b1;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("tx", 32'(tx), 32'(exp_tx));
      check("busy", 32'(busy), 32'(exp_busy));
      check("done", 32'(done), 32'(exp_done));
      if (done === 1'b1) obs_done_cnt++;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_report();
    report = 1'b1;
    step(1);
    report = 1'b0;
  endtask

  task automatic wait_idle();
    int guard = 0;
    while ((busy !== 1'b0 || m_pend) && guard < 3 * FRAME) begin
      step(1);
      guard++;
    end
    check("idle_timeout", 32'(guard < 3 * FRAME), 32'd1);
    step(2);
  endtask

  initial begin
    step(3);
    rst = 1'b0;

    // 1: idle line after reset
    step(100);
    check("idle_dones", 32'(obs_done_cnt), 32'd0);

    // 2: basic frame, state 2 relay 1
    state_in = 2'd2; relay_in = 1'b1;
    pulse_report();
    check("start_tx", 32'(tx), 32'd0);
    check("start_busy", 32'(busy), 32'd1);
    step(FRAME - 1);
    check("last_busy", 32'(busy), 32'd1);
    step(1);
    check("done_pulse", 32'(done), 32'd1);
    check("busy_fall", 32'(busy), 32'd0);
    wait_idle();

    // 3: inputs change mid-frame
    state_in = 2'd0; relay_in = 1'b0;
    pulse_report();
    step(49);
    state_in = 2'd3; relay_in = 1'b1;
    wait_idle();

    // 4: three reports during a frame collapse to one extra frame
    state_in = 2'd1; relay_in = 1'b0;
    begin
      int d0;
      d0 = obs_done_cnt;
      pulse_report();
      step(100); pulse_report();
      step(100); pulse_report();
      step(100); pulse_report();
      wait_idle();
      step(FRAME);
      check("extra_frames", 32'(obs_done_cnt - d0), 32'd2);
    end

    // 5: report coincident with done
    pulse_report();
    step(FRAME - 1);
    check("pre_done_busy", 32'(busy), 32'd1);
    step(1);
    check("coinc_done", 32'(done), 32'd1);
    report = 1'b1;
    step(1);
    report = 1'b0;
    check("b2b_tx", 32'(tx), 32'd0);
    check("b2b_busy", 32'(busy), 32'd1);
    wait_idle();

    // 6: reset mid-frame, then a clean frame
    pulse_report();
    step(199);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    step(FRAME);
    state_in = 2'd3; relay_in = 1'b1;
    pulse_report();
    wait_idle();

    // Randomized traffic with occasional resets
    for (int i = 0; i < 6000; i++) begin
      report   = ($urandom_range(0, 99) < 2);
      state_in = 2'($urandom);
      relay_in = 1'($urandom);
      rst      = ($urandom_range(0, 1499) == 0);
      step(1);
    end
    report = 1'b0;
    rst    = 1'b0;
    wait_idle();

    check("done_count", 32'(obs_done_cnt), 32'(m_done_cnt));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
